// File: rtl/tc_feeder_if.sv
// Element stream in, packed-row burst out: the feeder's whole external bus.
interface tc_feeder_if #(
    parameter int DW_MUL = 8,
    parameter int K      = 16
);
    logic                        s_valid;
    logic                        s_ready;
    logic signed [DW_MUL-1:0]    s_data;
    logic [DW_MUL*K-1:0]         in_i;
    logic                        in_type;
    logic                        in_state;
    logic                        enable;
    logic                        done;

    // Producer side: streams elements and observes the burst.
    modport master (
        output s_valid, s_data,
        input  s_ready, in_i, in_type, in_state, enable, done
    );

    // Feeder side.
    modport slave (
        input  s_valid, s_data,
        output s_ready, in_i, in_type, in_state, enable, done
    );
endinterface

// File: rtl/tc_feeder.sv
// tc_feeder: packs a stream of signed elements into K-wide rows (M rows of A,
// then N rows of B), then replays the whole job to tc_ctrl as one contiguous
// burst framed by in_state pulses, holds enable through a drain window and
// pulses done.
module tc_feeder #(
    parameter int M      = 16,
    parameter int K      = 16,
    parameter int N      = 16,
    parameter int DW_MUL = 8,
    parameter int DRAIN  = 128
) (
    input  logic        clk,
    input  logic        reset,
    tc_feeder_if.slave  bus
);
    localparam int ROWS = M + N;
    localparam int RW   = DW_MUL * K;
    localparam int LW   = (K > 1) ? $clog2(K) : 1;
    localparam int RIW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DCW  = $clog2(DRAIN) + 1;

    localparam logic [2:0] S_LOAD   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_SEND_A = 3'd2;
    localparam logic [2:0] S_SEND_B = 3'd3;
    localparam logic [2:0] S_END    = 3'd4;
    localparam logic [2:0] S_DRAIN  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [2:0]              state_q, state_d;
    logic [LW-1:0]           lane_q, lane_d;    // lane of next element to store
    logic [RIW-1:0]          row_q, row_d;      // load row, or row being replayed
    logic [DCW-1:0]          drain_q, drain_d;
    logic [ROWS-1:0][RW-1:0] rbuf_q, rbuf_d;

    logic          s_ready_q, s_ready_d;
    logic [RW-1:0] in_i_q, in_i_d;
    logic          in_type_q, in_type_d;
    logic          in_state_q, in_state_d;
    logic          enable_q, enable_d;
    logic          done_q, done_d;

    logic accept;
    assign accept = bus.s_valid && s_ready_q;

    // Sequencer: element packing during LOAD, then row/drain counting.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        row_d   = row_q;
        drain_d = drain_q;
        rbuf_d  = rbuf_q;
        case (state_q)
            S_LOAD: begin
                if (accept) begin
                    rbuf_d[row_q][DW_MUL*lane_q +: DW_MUL] = bus.s_data;
                    if (lane_q == LW'(K-1)) begin
                        lane_d = '0;
                        if (row_q == RIW'(ROWS-1)) begin
                            row_d   = '0;
                            state_d = S_START;
                        end else begin
                            row_d = row_q + RIW'(1);
                        end
                    end else begin
                        lane_d = lane_q + LW'(1);
                    end
                end
            end
            S_START: begin
                row_d   = '0;
                state_d = S_SEND_A;
            end
            S_SEND_A: begin
                row_d = row_q + RIW'(1);
                if (row_q == RIW'(M-1))
                    state_d = S_SEND_B;
            end
            S_SEND_B: begin
                // Row index stays on the last B row so END/DRAIN keep showing it.
                if (row_q == RIW'(ROWS-1))
                    state_d = S_END;
                else
                    row_d = row_q + RIW'(1);
            end
            S_END: begin
                drain_d = '0;
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_q == DCW'(DRAIN-1))
                    state_d = S_DONE;
                else
                    drain_d = drain_q + DCW'(1);
            end
            S_DONE: begin
                row_d   = '0;
                lane_d  = '0;
                state_d = S_LOAD;
            end
            default: state_d = S_LOAD;
        endcase
    end

    // Output decode from the next state so every output comes straight off a flop.
    always_comb begin
        s_ready_d  = (state_d == S_LOAD);
        enable_d   = (state_d != S_LOAD);
        in_state_d = (state_d == S_START) || (state_d == S_END);
        done_d     = (state_d == S_DONE);
        in_i_d     = in_i_q;
        in_type_d  = in_type_q;
        case (state_d)
            S_LOAD, S_START: begin
                in_i_d    = '0;
                in_type_d = 1'b0;
            end
            S_SEND_A: begin
                in_i_d    = rbuf_q[row_d];
                in_type_d = 1'b0;
            end
            S_SEND_B: begin
                in_i_d    = rbuf_q[row_d];
                in_type_d = 1'b1;
            end
            S_END:   in_type_d = 1'b1;
            default: ;
        endcase
    end

    // State, counters, row buffer and output registers; reset discards the job.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_LOAD;
            lane_q     <= '0;
            row_q      <= '0;
            drain_q    <= '0;
            rbuf_q     <= '0;
            s_ready_q  <= 1'b0;
            in_i_q     <= '0;
            in_type_q  <= 1'b0;
            in_state_q <= 1'b0;
            enable_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            row_q      <= row_d;
            drain_q    <= drain_d;
            rbuf_q     <= rbuf_d;
            s_ready_q  <= s_ready_d;
            in_i_q     <= in_i_d;
            in_type_q  <= in_type_d;
            in_state_q <= in_state_d;
            enable_q   <= enable_d;
            done_q     <= done_d;
        end
    end

    assign bus.s_ready  = s_ready_q;
    assign bus.in_i     = in_i_q;
    assign bus.in_type  = in_type_q;
    assign bus.in_state = in_state_q;
    assign bus.enable   = enable_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_tc_feeder.sv
// Bench for tc_feeder: randomized element streams, expected rows/start times
// queued by the stimulus, checked by an independent burst monitor.
module tb_tc_feeder;
    localparam int M     = 16;
    localparam int K     = 16;
    localparam int N     = 16;
    localparam int DW    = 8;
    localparam int DRAIN = 128;
    localparam int ROWS  = M + N;
    localparam int TOT   = ROWS * K;
    localparam int RW    = DW * K;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    int   last_acc = 0;
    int   first_acc = 0;

    logic [DW-1:0] elems [TOT];
    logic [RW-1:0] exp_rows [$];
    int            exp_start [$];

    tc_feeder_if #(.DW_MUL(DW), .K(K)) bus ();

    tc_feeder #(.M(M), .K(K), .N(N), .DW_MUL(DW), .DRAIN(DRAIN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_r(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @%0d: got %0d want %0d", name, cyc, act, exp);
        end
    endtask

    // Reference: element e lands in row e/K, lane e%K, unmodified.
    task automatic build_job(input int mode);
        for (int e = 0; e < TOT; e++) begin
            int r, l;
            r = e / K;
            l = e % K;
            case (mode)
                0: elems[e] = (r < M) ? ((l == r) ? 8'd1 : 8'd0) : ((l == r - M) ? 8'd1 : 8'd0);
                1: elems[e] = (r < M) ? DW'((e % 256) - 128) : DW'($urandom);
                2: elems[e] = (e % 2 == 0) ? 8'h80 : 8'h7F;
                default: elems[e] = DW'($urandom);
            endcase
        end
        for (int r = 0; r < ROWS; r++) begin
            logic [RW-1:0] row;
            row = '0;
            for (int l = 0; l < K; l++) row[DW*l +: DW] = elems[r*K + l];
            exp_rows.push_back(row);
        end
    endtask

    // Called at posedge+#1; returns at posedge+#1 after the element is taken.
    task automatic push_elem(input logic [DW-1:0] v, input int gap_pct);
        int guard;
        while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
            bus.s_valid = 1'b0;
            bus.s_data  = DW'($urandom);
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b1;
        bus.s_data  = v;
        guard = 0;
        forever begin
            @(negedge clk);
            if (bus.s_ready) break;
            guard++;
            if (guard > 4000) begin
                n_err++;
                $display("FAIL accept_timeout: s_ready stuck low at cycle %0d", cyc);
                $display("Result: errors=%0d of %0d checks", n_err, n_chk);
                $fatal(1, "accept timeout");
            end
        end
        last_acc = cyc;
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        bus.s_data  = DW'($urandom);
    endtask

    task automatic send_job(input int mode, input int gap_pct);
        build_job(mode);
        for (int e = 0; e < TOT; e++) begin
            push_elem(elems[e], gap_pct);
            if (e == 0) first_acc = last_acc;
        end
        exp_start.push_back(last_acc + 1);
    endtask

    task automatic wait_done(output int dcyc);
        int guard;
        guard = 0;
        dcyc = -1;
        forever begin
            @(negedge clk);
            if (bus.done) begin
                dcyc = cyc;
                break;
            end
            guard++;
            if (guard > 3000) begin
                chk_i("done_timeout", 0, 1);
                break;
            end
        end
    endtask

    // Monitor: walks each burst from its START pulse and checks it cycle by cycle.
    initial begin : monitor
        bit ab;
        int bad;
        logic [RW-1:0] exp, last;
        forever begin
            @(negedge clk);
            if (reset || !bus.in_state) continue;
            chk_i("start_cycle", cyc, (exp_start.size() != 0) ? exp_start.pop_front() : -1);
            chk_r("start_in_i", bus.in_i, '0);
            chk_i("start_type", int'(bus.in_type), 0);
            chk_i("start_enable", int'(bus.enable), 1);
            chk_i("start_s_ready", int'(bus.s_ready), 0);
            ab = 0;
            last = '0;
            for (int i = 0; i < ROWS; i++) begin
                @(negedge clk);
                if (reset) begin ab = 1; break; end
                exp = (exp_rows.size() != 0) ? exp_rows.pop_front() : {RW{1'bx}};
                chk_r("row_data", bus.in_i, exp);
                chk_i("row_type", int'(bus.in_type), (i >= M) ? 1 : 0);
                chk_i("row_framing", int'(bus.in_state), 0);
                last = exp;
            end
            if (ab) begin exp_rows.delete(); continue; end
            @(negedge clk);
            if (reset) begin exp_rows.delete(); continue; end
            chk_i("end_pulse", int'(bus.in_state), 1);
            chk_i("end_type", int'(bus.in_type), 1);
            chk_r("end_in_i", bus.in_i, last);
            chk_i("end_enable", int'(bus.enable), 1);
            bad = 0;
            for (int d = 0; d < DRAIN; d++) begin
                @(negedge clk);
                if (reset) begin ab = 1; break; end
                if (!bus.enable || bus.in_state || bus.done || bus.s_ready ||
                    bus.in_i !== last || !bus.in_type) bad++;
            end
            if (ab) begin exp_rows.delete(); continue; end
            chk_i("drain_window", bad, 0);
            @(negedge clk);
            if (reset) continue;
            chk_i("done_pulse", int'(bus.done), 1);
            chk_i("done_enable", int'(bus.enable), 1);
            if (bus.done) done_cnt++;
            @(negedge clk);
            if (reset) continue;
            chk_i("reload_ready", int'(bus.s_ready), 1);
            chk_i("load_enable", int'(bus.enable), 0);
            chk_i("load_done_low", int'(bus.done), 0);
        end
    end

    initial begin : stim
        int dc, d0, guard;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        reset = 1'b1;

        // Reset held 3 cycles: every output low.
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            chk_r("reset_outputs",
                  RW'({bus.s_ready, bus.enable, bus.in_state, bus.in_type, bus.done}) | bus.in_i, '0);
        end
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); @(negedge clk);
        chk_i("ready_after_reset", int'(bus.s_ready), 1);
        chk_i("enable_in_load", int'(bus.enable), 0);
        @(posedge clk); #1;

        // Identity job, no gaps.
        send_job(0, 0);
        chk_i("load_length", last_acc - first_acc, TOT - 1);
        wait_done(dc);
        chk_i("done_latency", dc - (last_acc + 1), M + N + DRAIN + 2);
        @(posedge clk); #1;

        // Backpressure / gaps with junk on idle cycles.
        send_job(1, 50);
        wait_done(dc);
        @(posedge clk); #1;

        // Signed extremes.
        send_job(2, 20);
        wait_done(dc);
        @(posedge clk); #1;

        // Reset on the 5th A row, then a fresh job.
        d0 = done_cnt;
        send_job(3, 0);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!bus.in_state && guard < 100);
        chk_i("abort_start_seen", int'(bus.in_state), 1);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); @(negedge clk);
        chk_r("abort_outputs",
              RW'({bus.s_ready, bus.enable, bus.in_state, bus.in_type, bus.done}) | bus.in_i, '0);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); @(negedge clk);
        chk_i("abort_ready", int'(bus.s_ready), 1);
        chk_i("abort_no_done", done_cnt, d0);
        @(posedge clk); #1;
        send_job(3, 30);
        wait_done(dc);
        @(posedge clk); #1;

        // Back-to-back jobs.
        d0 = done_cnt;
        send_job(3, 0);
        wait_done(dc);
        @(posedge clk); #1;
        send_job(1, 0);
        chk_i("b2b_first_accept", first_acc, dc + 1);
        wait_done(dc);
        repeat (4) @(negedge clk);
        chk_i("b2b_done_count", done_cnt - d0, 2);

        chk_i("total_done", done_cnt, 6);
        chk_i("rows_left", exp_rows.size(), 0);
        chk_i("starts_left", exp_start.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
